boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter RESET_HOLD, default 2, is the number of cycles cpu_reset stays high after loading ends.
REQ-002 Parameter IMEM_AW, default 12, is the instruction-memory word-address width.
REQ-003 Port clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  is the synchronous, active-high reset.
REQ-005 Port start  in  1  pulse that begins a load-and-run sequence.
REQ-006 Port prog_len  in  13  is the number of instruction words to load (1..4096).
REQ-007 Port max_cycles  in  32  is the run-cycle budget; 0 means unlimited.
REQ-008 Port halt_pc  in  32  is the PC value at or above which the program is finished.
REQ-009 Port in_valid / in_data  in  1 / 32  form the instruction word stream.
REQ-010 Port in_ready  out  1  signals that a word is accepted this cycle.
REQ-011 Port cpu_reset  out  1  drives the CPU reset.
REQ-012 Ports init_mode, write_enable  out  1 each, and init_address out IMEM_AW, and init_instruction out 32, drive the CPU instruction-memory load port.
REQ-013 Port pc_out  in  32  is the CPU program counter.
REQ-014 Ports busy, done, timeout  out  1 each, and run_cycles out 32, report status.

Function
REQ-015 States: IDLE, LOAD, RELEASE, RUN, DONE, TIMEOUT.
REQ-016 IDLE outputs: cpu_reset=1, init_mode=1, write_enable=0, in_ready=0, busy=0.
REQ-017 From IDLE, DONE or TIMEOUT, start=1 with prog_len!=0 latches prog_len and max_cycles, clears the word counter, done, timeout and run_cycles, and enters LOAD.
REQ-018 start with prog_len=0 is ignored; start while busy=1 is ignored.
REQ-019 LOAD: in_ready=1, init_mode=1, cpu_reset=1.
REQ-020 LOAD handshake: a word is accepted on an edge where in_valid and in_ready are both 1.
REQ-021 On acceptance, registered outputs in the following cycle are write_enable=1, init_address=word count, init_instruction=in_data; the word count then increments.
REQ-022 write_enable is 0 in any cycle not following an acceptance.
REQ-023 LOAD tolerates in_valid gaps of any length with no timeout.
REQ-024 When the accepted word is number prog_len-1, the block enters RELEASE; in_ready drops the next cycle, and the write pulse for that last word still occurs in the first RELEASE cycle.
REQ-025 RELEASE: init_mode=0, cpu_reset=1 for exactly RESET_HOLD cycles, then RUN.
REQ-026 RUN: cpu_reset=0, init_mode=0, busy=1, and run_cycles increments every cycle.
REQ-027 In RUN, pc_out >= halt_pc (unsigned) enters DONE.
REQ-028 In RUN with max_cycles!=0 and run_cycles reaching max_cycles, the block enters TIMEOUT.
REQ-029 When halt and timeout occur in the same cycle, the halt wins and the block enters DONE.
REQ-030 DONE/TIMEOUT: cpu_reset=1 (CPU frozen), busy=0, done or timeout held high (sticky), run_cycles frozen.
REQ-031 busy=1 exactly in LOAD, RELEASE and RUN.

Reset
REQ-032 reset=1 at any state, including mid-LOAD or mid-RUN, forces IDLE on the next edge.
REQ-033 Reset values: cpu_reset=1, init_mode=1, write_enable=0, init_address=0, init_instruction=0, in_ready=0, busy=0, done=0, timeout=0, run_cycles=0.
REQ-034 A partial load interrupted by reset is abandoned; a new start reloads from address 0.

Structure
REQ-035 Shared package boot_seq_pkg holds the state enum and the constant TEXT_BASE=32'h00400000.
REQ-036 The block is a single module; no sub-module is required.

Verification
REQ-037 Load 24 words with in_valid held high, halt_pc=0x00400060 -> 24 single-cycle write pulses at addresses 0..23, cpu_reset low RESET_HOLD cycles after the last write, then done=1 once pc_out>=0x00400060.
REQ-038 Stream with in_valid toggling 1,0,0,1 per word, prog_len=4 -> exactly 4 writes at addresses 0..3 with data in order and no duplicate writes.
REQ-039 max_cycles=50, halt_pc unreachable -> timeout=1 with run_cycles=50, done=0 and cpu_reset=1.
REQ-040 pc_out reaches halt_pc in the same cycle run_cycles reaches max_cycles -> done=1 and timeout=0.
REQ-041 reset asserted after 10 of 24 words -> all outputs at reset values next cycle; a subsequent start reloads from address 0.
REQ-042 start with prog_len=0, and start during RUN -> no state change.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// boot_seq_pkg: shared state encoding and memory-map constants for the boot sequencer.
package boot_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam int LEN_W = 13;
endpackage

// File: rtl/boot_sequencer_if.sv
// boot_sequencer_if: instruction stream, CPU reset and instruction-memory load port.
interface boot_sequencer_if #(
  parameter int IMEM_AW = 12
) ();
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic               cpu_reset;
  logic               init_mode;
  logic               write_enable;
  logic [IMEM_AW-1:0] init_address;
  logic [31:0]        init_instruction;
  logic [31:0]        pc_out;
  modport master (
    output in_valid, in_data, pc_out,
    input  in_ready, cpu_reset, init_mode, write_enable, init_address, init_instruction
  );
  modport slave (
    input  in_valid, in_data, pc_out,
    output in_ready, cpu_reset, init_mode, write_enable, init_address, init_instruction
  );
endinterface

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads a program into CPU instruction memory, releases reset, and supervises the run.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int RESET_HOLD = 2,
  parameter int IMEM_AW    = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] prog_len,
  input  logic [31:0]      max_cycles,
  input  logic [31:0]      halt_pc,
  boot_sequencer_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      run_cycles
);
  state_t           state, next;
  logic [LEN_W-1:0] len_q, cnt;
  logic [31:0]      max_q, hold_cnt;
  logic             launch, accept, last, halt_hit, budget_hit;
  always_comb begin
    launch     = start && prog_len != '0 &&
                 (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
    accept     = state == S_LOAD && bus.in_valid;
    last       = accept && cnt == len_q - 1'b1;
    halt_hit   = state == S_RUN && bus.pc_out >= halt_pc;
    budget_hit = state == S_RUN && max_q != '0 && run_cycles + 32'd1 == max_q;
    next = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: next = launch ? S_LOAD : state;
      S_LOAD:    next = last ? S_RELEASE : S_LOAD;
      S_RELEASE: next = hold_cnt + 32'd1 >= 32'(RESET_HOLD) ? S_RUN : S_RELEASE;
      S_RUN:     next = halt_hit ? S_DONE : budget_hit ? S_TIMEOUT : S_RUN;
      default:   next = S_IDLE;
    endcase
    bus.in_ready  = state == S_LOAD;
    bus.cpu_reset = state != S_RUN;
    bus.init_mode = state == S_IDLE || state == S_LOAD;
    busy          = state == S_LOAD || state == S_RELEASE || state == S_RUN;
  end
  // Memory writes are registered, so each pulse lands the cycle after its handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      len_q                <= '0;
      cnt                  <= '0;
      max_q                <= '0;
      hold_cnt             <= '0;
      bus.write_enable     <= 1'b0;
      bus.init_address     <= '0;
      bus.init_instruction <= '0;
      done                 <= 1'b0;
      timeout              <= 1'b0;
      run_cycles           <= '0;
    end else begin
      state            <= next;
      bus.write_enable <= accept;
      hold_cnt         <= state == S_RELEASE ? hold_cnt + 32'd1 : '0;
      if (accept) begin
        bus.init_address     <= cnt[IMEM_AW-1:0];
        bus.init_instruction <= bus.in_data;
        cnt                  <= cnt + 1'b1;
      end
      if (state == S_RUN) run_cycles <= run_cycles + 32'd1;
      if (halt_hit) done <= 1'b1;
      if (budget_hit && !halt_hit) timeout <= 1'b1;
      if (launch) begin
        len_q      <= prog_len;
        max_q      <= max_cycles;
        cnt        <= '0;
        done       <= 1'b0;
        timeout    <= 1'b0;
        run_cycles <= '0;
      end
    end
  end
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: directed load/run scenarios with a write-pulse scoreboard.
module tb_boot_sequencer;
  import boot_seq_pkg::*;
  localparam int HOLD = 2;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [12:0] prog_len = '0;
  logic [31:0] max_cycles = '0, halt_pc = '0;
  logic        busy, done, timeout;
  logic [31:0] run_cycles;
  int          checks = 0, errors = 0;
  logic [63:0] exp_q[$];
  boot_sequencer_if #(.IMEM_AW(12)) bus ();
  boot_sequencer #(.RESET_HOLD(HOLD), .IMEM_AW(12)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len),
    .max_cycles(max_cycles), .halt_pc(halt_pc), .bus(bus),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.init_address, bus.init_instruction);
      end else chk("write", {20'd0, bus.init_address, bus.init_instruction}, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [12:0] len, input logic [31:0] maxc);
    start = 1'b1;
    prog_len = len;
    max_cycles = maxc;
    tick();
    start = 1'b0;
  endtask
  task automatic load(input logic [7:0] tag, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d;
      logic acc;
      d = {tag, i[23:0]};
      bus.in_valid = 1'b1;
      bus.in_data = d;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        acc = bus.in_ready;
        tick();
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL load_accept: got no in_ready for word %0d expected acceptance", i);
      end else exp_q.push_back({20'd0, i[11:0], d});
      bus.in_valid = 1'b0;
      bus.in_data = 32'hDEAD_0000 | i;
      if (i < n - 1) repeat (gap) tick();
    end
  endtask
  task automatic release_phase();
    for (int k = 0; k < HOLD; k++) begin
      chk("release_cpu_reset", bus.cpu_reset, 1);
      chk("release_init_mode", bus.init_mode, 0);
      tick();
    end
    chk("run_cpu_reset", bus.cpu_reset, 0);
    chk("run_busy", busy, 1);
    chk("run_start_cycles", run_cycles, 0);
  endtask
  task automatic chk_reset_vals();
    chk("rst_cpu_reset", bus.cpu_reset, 1);
    chk("rst_init_mode", bus.init_mode, 1);
    chk("rst_write_enable", bus.write_enable, 0);
    chk("rst_init_address", bus.init_address, 0);
    chk("rst_init_instruction", bus.init_instruction, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_run_cycles", run_cycles, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end within time limit");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.pc_out = TEXT_BASE;
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    // 24 words back to back, then halt by PC
    halt_pc = TEXT_BASE + 32'h60;
    launch(24, 0);
    chk("load_busy", busy, 1);
    chk("load_in_ready", bus.in_ready, 1);
    chk("load_cpu_reset", bus.cpu_reset, 1);
    chk("load_init_mode", bus.init_mode, 1);
    load(8'h11, 24, 0);
    chk("release_in_ready", bus.in_ready, 0);
    release_phase();
    repeat (5) begin
      bus.pc_out = bus.pc_out + 32'd4;
      tick();
    end
    chk("run_cycles_5", run_cycles, 5);
    bus.pc_out = halt_pc;
    tick();
    chk("halt_done", done, 1);
    chk("halt_timeout", timeout, 0);
    chk("halt_busy", busy, 0);
    chk("halt_cpu_reset", bus.cpu_reset, 1);
    chk("halt_run_cycles", run_cycles, 6);
    repeat (3) tick();
    chk("done_sticky", done, 1);
    chk("done_frozen_cycles", run_cycles, 6);
    chk("q_empty_1", exp_q.size(), 0);
    launch(0, 0);
    chk("zero_len_busy", busy, 0);
    chk("zero_len_done", done, 1);
    // gapped stream, and start ignored while running
    bus.pc_out = TEXT_BASE;
    halt_pc = TEXT_BASE + 32'h10;
    launch(4, 0);
    chk("restart_done_clr", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_cycles_clr", run_cycles, 0);
    load(8'h22, 4, 2);
    release_phase();
    repeat (3) tick();
    chk("run2_cycles", run_cycles, 3);
    launch(7, 0);
    chk("start_in_run_busy", busy, 1);
    chk("start_in_run_cpu_reset", bus.cpu_reset, 0);
    chk("start_in_run_in_ready", bus.in_ready, 0);
    chk("start_in_run_cycles", run_cycles, 4);
    bus.pc_out = halt_pc;
    tick();
    chk("run2_done", done, 1);
    chk("run2_cycles_final", run_cycles, 5);
    chk("q_empty_2", exp_q.size(), 0);
    // cycle budget expires
    bus.pc_out = TEXT_BASE;
    halt_pc = 32'hFFFF_FFFF;
    launch(2, 50);
    load(8'h33, 2, 0);
    release_phase();
    for (int t = 0; t < 200 && !(timeout || done); t++) tick();
    chk("to_timeout", timeout, 1);
    chk("to_done", done, 0);
    chk("to_run_cycles", run_cycles, 50);
    chk("to_cpu_reset", bus.cpu_reset, 1);
    chk("to_busy", busy, 0);
    // halt and budget in the same cycle
    halt_pc = TEXT_BASE + 32'h20;
    launch(1, 8);
    load(8'h44, 1, 0);
    release_phase();
    repeat (7) tick();
    chk("tie_pre_timeout", timeout, 0);
    chk("tie_pre_cycles", run_cycles, 7);
    bus.pc_out = halt_pc;
    tick();
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_cycles", run_cycles, 8);
    // reset in the middle of a load, then reload from 0
    bus.pc_out = TEXT_BASE;
    halt_pc = TEXT_BASE + 32'h8;
    launch(24, 0);
    load(8'h55, 10, 0);
    chk("midload_busy", busy, 1);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    launch(3, 0);
    load(8'h66, 3, 0);
    release_phase();
    bus.pc_out = halt_pc;
    tick();
    chk("reload_done", done, 1);
    chk("q_empty_3", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
